// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with one write port, two
// combinational read ports and a per-register busy scoreboard.
//
// Ports:
//   Clock, Reset           rising-edge clock, asynchronous active-low reset
//   WriteEnable, SelectInput, In
//                          write port, committed at the rising edge
//   SelectA/SelectB -> A/B combinational read ports
//   ReadEnA/ReadEnB        operand needed this cycle, qualifies Stall
//   ReserveEn, ReserveSel  mark a register busy for a multi-cycle producer
//   BusyA/BusyB            selected register has a pending write
//   Stall                  a needed operand is still pending
//   BusyCount              registered popcount of the busy vector
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - same-cycle forwarding of In to A/B, busy masked by the write
//   undefined - A/B return the stored value, busy is unmasked
module reg_file_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned R0_ZERO = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] SelectInput,
  input  logic [DATA_W-1:0] In,
  input  logic [ADDR_W-1:0] SelectA,
  input  logic [ADDR_W-1:0] SelectB,
  input  logic              ReadEnA,
  input  logic              ReadEnB,
  input  logic              ReserveEn,
  input  logic [ADDR_W-1:0] ReserveSel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              BusyA,
  output logic              BusyB,
  output logic              Stall,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          R0_Z  = (R0_ZERO != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  busy_count_q, busy_count_d;

  logic write_ok;
  logic reserve_ok;
  logic zero_a, zero_b;
  logic [DATA_W-1:0] stored_a, stored_b;

  // Writes and reserves aimed at a hard-wired zero register are dropped.
  always_comb begin
    write_ok   = WriteEnable & ~(R0_Z & (SelectInput == '0));
    reserve_ok = ReserveEn & ~(R0_Z & (ReserveSel == '0));
  end

  // Next register contents and scoreboard; reserve is applied after the
  // write-clear so a new producer overrides the completing one.
  always_comb begin
    regs_d       = regs_q;
    busy_d       = busy_q;
    busy_count_d = '0;
    if (write_ok) begin
      regs_d[SelectInput] = In;
      busy_d[SelectInput] = 1'b0;
    end
    if (reserve_ok) begin
      busy_d[ReserveSel] = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + CNT_W'(busy_d[i]);
    end
  end

  // State registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Stored read values; a zero register reads 0 regardless of contents.
  always_comb begin
    zero_a   = R0_Z & (SelectA == '0);
    zero_b   = R0_Z & (SelectB == '0);
    stored_a = zero_a ? '0 : regs_q[SelectA];
    stored_b = zero_b ? '0 : regs_q[SelectB];
  end

`ifdef REGFILE_BYPASS_EN
  logic hit_a, hit_b;

  // This cycle's write both supplies the operand and resolves the hazard.
  always_comb begin
    hit_a = write_ok & (SelectInput == SelectA);
    hit_b = write_ok & (SelectInput == SelectB);
    A     = hit_a ? In : stored_a;
    B     = hit_b ? In : stored_b;
    BusyA = busy_q[SelectA] & ~hit_a;
    BusyB = busy_q[SelectB] & ~hit_b;
  end
`else
  // No bypass: the written value and cleared busy bit appear next cycle.
  always_comb begin
    A     = stored_a;
    B     = stored_b;
    BusyA = busy_q[SelectA];
    BusyB = busy_q[SelectB];
  end
`endif

  always_comb begin
    Stall     = (ReadEnA & BusyA) | (ReadEnB & BusyB);
    BusyCount = busy_count_q;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: two instances (16x16 normal register 0,
// 32x32 with hard-wired zero register) share one stimulus stream. The driver
// pushes predicted outputs from an array model; a negedge monitor pops and
// compares.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, we, rea, reb, res;
  logic [4:0]  si, sa, sb, rs;
  logic [31:0] din;

  logic [15:0] a0, b0;
  logic        ba0, bb0, st0;
  logic [4:0]  cnt0;
  logic [31:0] a1, b1;
  logic        ba1, bb1, st1;
  logic [5:0]  cnt1;

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .R0_ZERO(0)) u_dut0 (
    .Clock(clk), .Reset(rst_n), .WriteEnable(we), .SelectInput(si[3:0]),
    .In(din[15:0]), .SelectA(sa[3:0]), .SelectB(sb[3:0]), .ReadEnA(rea),
    .ReadEnB(reb), .ReserveEn(res), .ReserveSel(rs[3:0]), .A(a0), .B(b0),
    .BusyA(ba0), .BusyB(bb0), .Stall(st0), .BusyCount(cnt0)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1)) u_dut1 (
    .Clock(clk), .Reset(rst_n), .WriteEnable(we), .SelectInput(si),
    .In(din), .SelectA(sa), .SelectB(sb), .ReadEnA(rea),
    .ReadEnB(reb), .ReserveEn(res), .ReserveSel(rs), .A(a1), .B(b1),
    .BusyA(ba1), .BusyB(bb1), .Stall(st1), .BusyCount(cnt1)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Behavioural model: plain arrays of contents and busy flags per instance.
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];

  function automatic int depth(input int k);
    return (k == 1) ? 32 : 16;
  endfunction

  function automatic logic [31:0] msk(input int k);
    return (k == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit r0z(input int k);
    return k == 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = '0;
        mbusy[k][i] = 0;
      end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int wi = int'(si) % depth(k);
      int ri = int'(rs) % depth(k);
      if (we && !(r0z(k) && wi == 0)) begin
        mreg[k][wi]  = din & msk(k);
        mbusy[k][wi] = 0;
      end
      if (res && !(r0z(k) && ri == 0)) mbusy[k][ri] = 1;
    end
  endtask

  function automatic logic [31:0] rd(input int k, input int idx);
    int wi = int'(si) % depth(k);
    if (r0z(k) && idx == 0) return '0;
    if (BYP && we && wi == idx) return din & msk(k);
    return mreg[k][idx];
  endfunction

  function automatic bit bsy(input int k, input int idx);
    int wi = int'(si) % depth(k);
    if (r0z(k) && idx == 0) return 0;
    if (BYP && we && wi == idx) return 0;
    return mbusy[k][idx];
  endfunction

  function automatic exp_t predict(input int k);
    exp_t e;
    int   n = 0;
    int   ai = int'(sa) % depth(k);
    int   bi = int'(sb) % depth(k);
    e.a  = rd(k, ai);
    e.b  = rd(k, bi);
    e.ba = bsy(k, ai);
    e.bb = bsy(k, bi);
    e.st = (rea & e.ba) | (reb & e.bb);
    for (int i = 0; i < depth(k); i++) n += int'(mbusy[k][i]);
    e.cnt = 6'(n);
    return e;
  endfunction

  // One cycle: model absorbs the edge, then new inputs are driven and the
  // expected response queued.
  task automatic cyc(input bit rn, input bit w, input logic [4:0] s_in,
                     input logic [31:0] d, input logic [4:0] s_a, input logic [4:0] s_b,
                     input bit ra, input bit rb, input bit r, input logic [4:0] r_s);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    rst_n = rn; we = w; si = s_in; din = d; sa = s_a; sb = s_b;
    rea = ra; reb = rb; res = r; rs = r_s;
    if (!rn) model_reset();
    q0.push_back(predict(0));
    q1.push_back(predict(1));
  endtask

  task automatic idle(input logic [4:0] s_a, input bit ra);
    cyc(1, 0, 5'd0, 32'd0, s_a, s_a, ra, 0, 0, 5'd0);
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("a0", {16'd0, a0}, e.a);
      check("b0", {16'd0, b0}, e.b);
      check("busy_a0", {31'd0, ba0}, {31'd0, e.ba});
      check("busy_b0", {31'd0, bb0}, {31'd0, e.bb});
      check("stall0", {31'd0, st0}, {31'd0, e.st});
      check("count0", {27'd0, cnt0}, {26'd0, e.cnt});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("a1", a1, e.a);
      check("b1", b1, e.b);
      check("busy_a1", {31'd0, ba1}, {31'd0, e.ba});
      check("busy_b1", {31'd0, bb1}, {31'd0, e.bb});
      check("stall1", {31'd0, st1}, {31'd0, e.st});
      check("count1", {26'd0, cnt1}, {26'd0, e.cnt});
    end
  end

  initial begin
    rst_n = 0; we = 0; rea = 0; reb = 0; res = 0;
    si = '0; sa = '0; sb = '0; rs = '0; din = '0;
    model_reset();
    cyc(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0);
    idle(5'd0, 0);

    // Asynchronous reset clears contents and busy before the next edge.
    cyc(1, 1, 5'd5, 32'hBEEF, 5'd0, 5'd0, 0, 0, 0, 5'd0);
    cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0, 1, 5'd3);
    cyc(1, 0, 5'd0, 32'd0, 5'd5, 5'd3, 1, 1, 0, 5'd0);
    #1 check("pre_reset_r5", {16'd0, a0}, 32'h0000_BEEF);
    cyc(0, 0, 5'd0, 32'd0, 5'd5, 5'd3, 1, 1, 0, 5'd0);
    #1 check("reset_r5", {16'd0, a0}, 32'd0);
    check("reset_busy_r3", {31'd0, bb0}, 32'd0);
    check("reset_count", {27'd0, cnt0}, 32'd0);
    idle(5'd0, 0);

    // Write gating.
    cyc(1, 0, 5'd7, 32'h1234, 5'd7, 5'd7, 0, 0, 0, 5'd0);
    idle(5'd7, 0);
    #1 check("gated_r7", {16'd0, a0}, 32'd0);
    cyc(1, 1, 5'd7, 32'h1234, 5'd0, 5'd0, 0, 0, 0, 5'd0);
    idle(5'd7, 0);
    #1 check("written_r7", {16'd0, a0}, 32'h1234);

    // Forwarding on both ports.
    cyc(1, 1, 5'd2, 32'h0011, 5'd0, 5'd0, 0, 0, 0, 5'd0);
    cyc(1, 1, 5'd2, 32'h0022, 5'd2, 5'd2, 0, 0, 0, 5'd0);
    #1 check("fwd_a", {16'd0, a0}, BYP ? 32'h0022 : 32'h0011);
    check("fwd_b", {16'd0, b0}, BYP ? 32'h0022 : 32'h0011);
    idle(5'd2, 0);

    // Scoreboard stall and release.
    cyc(1, 0, 5'd0, 32'd0, 5'd4, 5'd4, 1, 0, 1, 5'd4);
    idle(5'd4, 1);
    #1 check("sb_count1", {27'd0, cnt0}, 32'd1);
    check("sb_stall", {31'd0, st0}, 32'd1);
    idle(5'd4, 1);
    cyc(1, 1, 5'd4, 32'h00AA, 5'd4, 5'd4, 1, 0, 0, 5'd0);
    #1 check("sb_write_stall", {31'd0, st0}, BYP ? 32'd0 : 32'd1);
    idle(5'd4, 1);
    #1 check("sb_released", {31'd0, st0}, 32'd0);
    check("sb_value", {16'd0, a0}, 32'h00AA);
    check("sb_count0", {27'd0, cnt0}, 32'd0);

    // Reserve and write to the same register: reserve wins.
    cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0, 1, 5'd9);
    cyc(1, 1, 5'd9, 32'h5555, 5'd0, 5'd0, 0, 0, 1, 5'd9);
    idle(5'd9, 0);
    #1 check("simul_val", {16'd0, a0}, 32'h5555);
    check("simul_busy", {31'd0, ba0}, 32'd1);
    check("simul_count", {27'd0, cnt0}, 32'd1);
    cyc(1, 1, 5'd9, 32'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0);

    // Hard-wired zero register and full reservation.
    cyc(1, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1, 0, 1, 5'd0);
    idle(5'd0, 1);
    #1 check("r0_val", a1, 32'd0);
    check("r0_busy", {31'd0, ba1}, 32'd0);
    check("r0_count", {26'd0, cnt1}, 32'd0);
    for (int i = 1; i < 32; i++)
      cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0, 1, 5'(i));
    idle(5'd0, 0);
    #1 check("full_count1", {26'd0, cnt1}, 32'd31);
    check("full_count0", {27'd0, cnt0}, 32'd16);

    // Randomised traffic, including occasional mid-run resets.
    for (int n = 0; n < 800; n++) begin
      logic [4:0] s_in = 5'($urandom);
      cyc(($urandom % 64) != 0, 1'($urandom), s_in, $urandom,
          ($urandom % 2 == 0) ? s_in : 5'($urandom),
          ($urandom % 2 == 0) ? s_in : 5'($urandom),
          1'($urandom), 1'($urandom), ($urandom % 3) == 0, 5'($urandom));
    end
    idle(5'd0, 0);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
